// File: rtl/pair_pkg.sv
// Shared types for the operand pair packer: the byte type, the {hi, lo} pair
// stored in the FIFO, and the packer FSM state encoding.
package pair_pkg;

   typedef logic [7:0] byte_t;

   // hi occupies [15:8]; it is the first byte of the pair and drives output a.
   typedef struct packed {
      byte_t hi;
      byte_t lo;
   } pair_t;

   typedef enum logic {
      HI = 1'b0,
      LO = 1'b1
   } pack_state_t;

endpackage

// File: rtl/pair_fifo.sv
// Small synchronous FIFO of byte pairs. Pointers wrap modulo DEPTH (a power of
// two), and level counts the stored entries from 0 to DEPTH inclusive.
module pair_fifo
   import pair_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int LVL_W = $clog2(DEPTH) + 1,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  pair_t            wdata,
   output pair_t            head,
   output logic [LVL_W-1:0] level,
   output logic             empty,
   output logic             full
);

   pair_t            mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   // Pushing into a full FIFO or popping an empty one is a no-op.
   assign empty   = (level == '0);
   assign full    = (level == LVL_W'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage is left unreset; stale entries are never visible because the
   // reader masks the head whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/operand_pair_packer.sv
// Packs a serial byte stream MSB-first into {a, b} pairs and buffers them in a
// pair FIFO, presenting the oldest pair to the downstream stage.
module operand_pair_packer
   import pair_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       a,
   output logic [7:0]       b,
   output logic [LVL_W-1:0] level
);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; valid may stay high while ready is low, and the payload
   // is only meaningful while valid is high.

   pack_state_t state_q;
   pack_state_t state_d;
   byte_t       hold_q;
   byte_t       hold_d;
   logic        accept;
   logic        push;
   logic        pop;
   logic        fifo_empty;
   logic        fifo_full;
   pair_t       push_pair;
   pair_t       head_pair;

   // The LO-state ready uses the registered full flag only; a pop in the
   // same cycle frees the slot for the following cycle, not this one.
   assign in_ready  = (state_q == HI) | ~fifo_full;
   assign accept    = in_valid & in_ready;
   assign push      = accept & (state_q == LO);
   assign out_valid = ~fifo_empty;
   assign pop       = out_valid & out_ready;
   assign push_pair = '{hi: hold_q, lo: in_data};

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      if (accept) begin
         case (state_q)
            HI: begin
               hold_d  = in_data;
               state_d = LO;
            end
            LO:      state_d = HI;
            default: state_d = HI;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_q <= HI;
         hold_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   pair_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .push  (push),
      .pop   (pop),
      .wdata (push_pair),
      .head  (head_pair),
      .level (level),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   always_comb begin
      a = 8'h00;
      b = 8'h00;
      if (out_valid) begin
         a = head_pair.hi;
         b = head_pair.lo;
      end
   end

endmodule

// File: tb/tb_operand_pair_packer.sv
// Directed bench for operand_pair_packer: reset, single pair, streaming,
// full back-pressure, pointer wrap under push/pop, and mid-pair flush.
module tb_operand_pair_packer;

   localparam int DEPTH = 4;
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic             clk;
   logic             rst;
   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_data;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       a;
   logic [7:0]       b;
   logic [LVL_W-1:0] level;

   int          n_checks;
   int          n_errors;
   logic [15:0] exp_q[$];
   logic        streaming;
   logic        stream_stall;
   int          max_level;

   operand_pair_packer #(
      .DEPTH(DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a         (a),
      .b         (b),
      .level     (level)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one byte and hold it until accepted, with a bounded wait.
   task automatic send_byte(input logic [7:0] d);
      int cnt;
      in_valid = 1'b1;
      in_data  = d;
      cnt      = 0;
      while (!in_ready && cnt < 50) begin
         step();
         cnt++;
      end
      check_eq("accept_wait", {15'd0, in_ready}, 16'd1);
      step();
      in_valid = 1'b0;
   endtask

   // scoreboard: every pop is compared against the expected queue
   always @(negedge clk) begin
      if (!rst && !clear && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_pair", {a, b}, 16'hxxxx);
         end else begin
            check_eq("pair", {a, b}, exp_q.pop_front());
         end
      end
      if (streaming) begin
         if (!in_ready) stream_stall = 1'b1;
         if (int'(level) > max_level) max_level = int'(level);
      end
   end

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      streaming    = 1'b0;
      stream_stall = 1'b0;
      max_level    = 0;
      rst          = 1'b1;
      clear        = 1'b0;
      in_valid     = 1'b1;
      in_data      = 8'hAA;
      out_ready    = 1'b0;

      // Reset held two cycles with a byte offered.
      repeat (2) step();
      check_eq("rst_out_valid", {15'd0, out_valid}, 16'd0);
      check_eq("rst_a", {8'd0, a}, 16'h00);
      check_eq("rst_b", {8'd0, b}, 16'h00);
      check_eq("rst_level", {13'd0, level}, 16'd0);
      check_eq("rst_in_ready", {15'd0, in_ready}, 16'd1);
      rst      = 1'b0;
      in_valid = 1'b0;
      step();

      // Single pair 01,02 with downstream stalled.
      send_byte(8'h01);
      check_eq("one_byte_no_pair", {15'd0, out_valid}, 16'd0);
      send_byte(8'h02);
      check_eq("single_valid", {15'd0, out_valid}, 16'd1);
      check_eq("single_ab", {a, b}, 16'h0102);
      check_eq("single_level", {13'd0, level}, 16'd1);
      repeat (2) step();
      check_eq("single_stable", {a, b}, 16'h0102);
      exp_q.push_back(16'h0102);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_eq("single_drained", {15'd0, out_valid}, 16'd0);
      check_eq("single_mask", {a, b}, 16'h0000);

      // Streaming with downstream always ready.
      exp_q.push_back(16'hff00);
      exp_q.push_back(16'h00ff);
      exp_q.push_back(16'hf0f0);
      exp_q.push_back(16'h0ff0);
      out_ready = 1'b1;
      streaming = 1'b1;
      send_byte(8'hff);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'hff);
      send_byte(8'hf0);
      send_byte(8'hf0);
      send_byte(8'h0f);
      send_byte(8'hf0);
      repeat (3) step();
      streaming = 1'b0;
      out_ready = 1'b0;
      check_eq("stream_no_stall", {15'd0, stream_stall}, 16'd0);
      check_eq("stream_max_level", 16'(max_level), 16'd1);
      check_eq("stream_drained", 16'(exp_q.size()), 16'd0);

      // Fill to DEPTH, then hold 0x18 and offer 0x19 under back-pressure.
      for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
      check_eq("full_level", {13'd0, level}, 16'd4);
      check_eq("full_hi_ready", {15'd0, in_ready}, 16'd1);
      send_byte(8'h18);
      check_eq("full_lo_ready", {15'd0, in_ready}, 16'd0);
      in_valid = 1'b1;
      in_data  = 8'h19;
      repeat (3) step();
      check_eq("full_held_ready", {15'd0, in_ready}, 16'd0);
      check_eq("full_held_level", {13'd0, level}, 16'd4);
      check_eq("full_head", {a, b}, 16'h1011);
      exp_q.push_back(16'h1011);
      exp_q.push_back(16'h1213);
      exp_q.push_back(16'h1415);
      exp_q.push_back(16'h1617);
      exp_q.push_back(16'h1819);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_eq("after_pop_ready", {15'd0, in_ready}, 16'd1);
      check_eq("after_pop_level", {13'd0, level}, 16'd3);
      step();
      in_valid = 1'b0;
      check_eq("refill_level", {13'd0, level}, 16'd4);
      out_ready = 1'b1;
      repeat (5) step();
      out_ready = 1'b0;
      check_eq("full_drained_level", {13'd0, level}, 16'd0);
      check_eq("full_drained_q", 16'(exp_q.size()), 16'd0);

      // Level 2 with simultaneous push/pop across several pointer wraps.
      exp_q.push_back(16'h2021);
      exp_q.push_back(16'h2223);
      send_byte(8'h20);
      send_byte(8'h21);
      send_byte(8'h22);
      send_byte(8'h23);
      check_eq("wrap_start_level", {13'd0, level}, 16'd2);
      for (int k = 0; k < 12; k++) begin
         exp_q.push_back({8'h30 + 8'(2 * k), 8'h31 + 8'(2 * k)});
         in_valid  = 1'b1;
         in_data   = 8'h30 + 8'(2 * k);
         out_ready = 1'b0;
         step();
         in_data   = 8'h31 + 8'(2 * k);
         out_ready = 1'b1;
         step();
         in_valid  = 1'b0;
         out_ready = 1'b0;
         check_eq("wrap_level", {13'd0, level}, 16'd2);
      end
      out_ready = 1'b1;
      repeat (3) step();
      out_ready = 1'b0;
      check_eq("wrap_drained", 16'(exp_q.size()), 16'd0);

      // clear mid-pair with a buffered pair, then a fresh pair.
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'hAB);
      check_eq("pre_clear_level", {13'd0, level}, 16'd1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check_eq("clear_level", {13'd0, level}, 16'd0);
      check_eq("clear_out_valid", {15'd0, out_valid}, 16'd0);
      send_byte(8'hCD);
      check_eq("clear_half_pair", {15'd0, out_valid}, 16'd0);
      send_byte(8'hEF);
      check_eq("clear_pair", {a, b}, 16'hCDEF);
      exp_q.push_back(16'hCDEF);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Same sequence with rst.
      send_byte(8'h05);
      send_byte(8'h06);
      send_byte(8'hAB);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("rst2_level", {13'd0, level}, 16'd0);
      check_eq("rst2_in_ready", {15'd0, in_ready}, 16'd1);
      send_byte(8'hCD);
      check_eq("rst2_half_pair", {15'd0, out_valid}, 16'd0);
      send_byte(8'hEF);
      check_eq("rst2_pair", {a, b}, 16'hCDEF);
      exp_q.push_back(16'hCDEF);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      step();

      check_eq("final_queue_empty", 16'(exp_q.size()), 16'd0);
      check_eq("final_level", {13'd0, level}, 16'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/operand_pair_packer.md
Name: operand_pair_packer

Overview:
- Upstream feeder for the byte-pair combinational `Device` (inputs a[7:0], b[7:0]).
- Takes a serial byte stream over a valid/ready handshake and packs consecutive bytes MSB-first into {a, b} pairs.
- Buffers completed pairs in a small FIFO and presents the head pair to the downstream stage with its own valid/ready handshake.
- Lets a byte-serial source drive the pair datapath at full rate without the source stalling on every pair.

Parameters:
- DEPTH, 4: pair FIFO entries; power of two, at least 2.
- LVL_W, $clog2(DEPTH)+1: width of the level output; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- clear  input  1  synchronous flush of the partial byte and all FIFO contents.
- in_valid  input  1  in_data holds a byte.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  8  stream byte.
- out_valid  output  1  a and b hold a complete pair.
- out_ready  input  1  downstream consumes the pair this cycle.
- a  output  8  high byte of the head pair (first byte received).
- b  output  8  low byte of the head pair (second byte received).
- level  output  LVL_W  number of complete pairs buffered.

Behaviour:
- Reset (rst=1 at an edge):
  - state=HI, hold register=8'h00, read/write pointers=0, level=0.
  - Visible next cycle: out_valid=0, a=b=8'h00, in_ready=1.
  - Any partial byte or buffered pair is discarded, including mid-pair.
  - rst takes priority over clear and over all handshakes.
- clear: identical effect to rst, except it is gated by rst priority.
- Packer FSM, two states:
  - HI, no byte held: in_ready=1 unconditionally. On accept: hold<=in_data, go to LO.
  - LO, high byte held: in_ready = (level != DEPTH), using registered level with no same-cycle pop bypass. On accept: push {hold, in_data} into the FIFO, go to HI.
- Accept means in_valid & in_ready at the edge. in_data is ignored when in_valid=0.
- Latency: the pair is visible on a/b with out_valid=1 in the cycle after the edge that accepts the second byte, when the FIFO was empty.
- FIFO:
  - out_valid = (level != 0).
  - Pop means out_valid & out_ready at the edge.
  - Push and pop in the same edge leave level unchanged; both pointers advance.
  - Pointers wrap modulo DEPTH.
  - level is never above DEPTH and never below 0. A pop with out_valid=0 is a no-op.
- Output masking: a and b read 8'h00 whenever out_valid=0; otherwise they show the head entry. They are stable while out_valid=1 and out_ready=0.
- Ordering: pairs leave strictly in arrival order. Byte order within a pair is first byte → a, second byte → b.
- Source rule: the upstream source may hold in_valid high across in_ready=0. The block never drops or duplicates a byte.

Decomposition:
- Shared package pair_pkg:
  - typedef byte_t (logic [7:0]).
  - typedef pair_t (packed struct {byte_t hi; byte_t lo;}), 16 bits, hi in [15:8].
  - enum pack_state_t {HI, LO}.
- Sub-module pair_fifo (DEPTH parameter, pair_t data):
  - push/pop/clear inputs; head, level, empty and full outputs.
  - Synchronous active-high reset on clk/rst.
- Top level holds the FSM, the hold register and output masking.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1, in_data=8'hAA → out_valid=0, a=b=00, level=0, in_ready=1. After release, no pair appears until 2 bytes are accepted.
- Single pair: bytes 01 then 02, out_ready=0 → one cycle after the 2nd accept, out_valid=1, a=01, b=02, level=1. Pulse out_ready → out_valid=0, a=b=00.
- Streaming with out_ready=1: ff,00,00,ff,f0,f0,0f,f0 → pairs (ff,00), (00,ff), (f0,f0), (0f,f0) in order; level ≤1; in_ready never low.
- Full: out_ready=0, send 2*DEPTH bytes plus 1 (0x10..0x18) → level=4. in_ready=0 in LO holding 0x18; in_valid stays high. One pop → in_ready=1 next cycle, pair (18,19) enqueued last, no byte lost.
- Simultaneous push/pop at level=2 → level stays 2; pops yield the correct order across pointer wrap (≥3 full rotations).
- clear/rst mid-pair: accept byte 0xAB (LO), assert clear → state HI, level=0. Next bytes 0xCD,0xEF give a=CD, b=EF. Repeat with rst instead of clear → same result.
